pixel_unpacker: RTL and testbench

PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

---
 rtl/pixel_unpacker.sv | 144 ++++++++++++++
 tb/tb_pixel_unpacker.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpacker.sv
// 32-bit AXI-Stream words (3 words = 4 x 24bpp pixels) to one-pixel valid/ready stream with x/y; 1-cycle latency, stalls input while output is held or P3 pending.
// Define PIXEL_UNPACKER_CHECK_EN to build the sticky sof_err/eol_err framing checks.
module pixel_unpacker #(
  parameter int X_SIZE = 1920,
  parameter int Y_SIZE = 1080
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic [3:0]  in_stream_tkeep,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        valid,
  input  logic        ready,
  output logic        sof,
  output logic        eol,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        sof_err,
  output logic        eol_err,
  input  logic        err_clr
);

  localparam logic [10:0] X_LAST = 11'(X_SIZE - 1);
  localparam logic [10:0] X_PEN  = 11'(X_SIZE - 2);
  localparam logic [10:0] Y_LAST = 11'(Y_SIZE - 1);

  typedef enum logic [1:0] {S_W0, S_W1, S_W2, S_P3} state_t;

  state_t      state, state_nxt;
  logic        run;
  logic        accept, load, as_w0;
  logic [23:0] stash, pix_nxt;
  logic [10:0] cx, cy, px, py;
  logic        unused_ok;

  assign accept = in_stream_tvalid && in_stream_tready;
  // SOF restarts a group regardless of where the FSM currently is.
  assign as_w0  = in_stream_tuser || (state == S_W0);
  assign load   = accept || ((state == S_P3) && (!valid || ready));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_W0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (as_w0)              state_nxt = S_W1;
      else if (state == S_W1) state_nxt = S_W2;
      else                    state_nxt = S_P3;
    end else if ((state == S_P3) && load) begin
      state_nxt = S_W0;
    end
  end

  // run keeps tready low throughout reset and the cycle it is released.
  always_comb begin
    in_stream_tready = run && (state != S_P3) && (!valid || ready);
  end

  always_comb begin
    pix_nxt = stash;
    if (accept) begin
      if (as_w0)              pix_nxt = in_stream_tdata[23:0];
      else if (state == S_W1) pix_nxt = {in_stream_tdata[15:0], stash[7:0]};
      else                    pix_nxt = {in_stream_tdata[7:0], stash[15:0]};
    end
    px = (accept && in_stream_tuser) ? 11'd0 : cx;
    py = (accept && in_stream_tuser) ? 11'd0 : cy;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run       <= 1'b0;
      valid     <= 1'b0;
      {r, g, b} <= 24'd0;
      x         <= 11'd0;
      y         <= 11'd0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      cx        <= 11'd0;
      cy        <= 11'd0;
      stash     <= 24'd0;
    end else begin
      run <= 1'b1;
      if (load) begin
        valid     <= 1'b1;
        {r, g, b} <= pix_nxt;
        x         <= px;
        y         <= py;
        sof       <= (px == 11'd0) && (py == 11'd0);
        eol       <= (px == X_LAST);
        if (px == X_LAST) begin
          cx <= 11'd0;
          cy <= (py == Y_LAST) ? 11'd0 : py + 11'd1;
        end else begin
          cx <= px + 11'd1;
          cy <= py;
        end
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (accept) begin
        if (as_w0)              stash <= {16'd0, in_stream_tdata[31:24]};
        else if (state == S_W1) stash <= {8'd0, in_stream_tdata[31:16]};
        else                    stash <= in_stream_tdata[31:8];
      end
    end
  end

`ifdef PIXEL_UNPACKER_CHECK_EN
  logic sof_set, eol_set, eol_word;

  assign sof_set  = accept && (in_stream_tuser ? ((state == S_W1) || (state == S_W2))
                                               : ((state == S_W0) && (cx == 11'd0) && (cy == 11'd0)));
  // Only W2 can finish the last pixel of a line (X_SIZE is a multiple of 4).
  assign eol_word = accept && !as_w0 && (state == S_W2) && (cx == X_PEN);
  assign eol_set  = accept && (in_stream_tlast != eol_word);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sof_err <= 1'b0;
      eol_err <= 1'b0;
    end else begin
      sof_err <= sof_set || (sof_err && !err_clr);
      eol_err <= eol_set || (eol_err && !err_clr);
    end
  end

  assign unused_ok = &{1'b0, in_stream_tkeep};
`else
  assign sof_err   = 1'b0;
  assign eol_err   = 1'b0;
  assign unused_ok = &{1'b0, in_stream_tkeep, in_stream_tlast, err_clr};
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomised bench for pixel_unpacker (8x2 frame) against a word-group reference model.
module tb_pixel_unpacker;

  localparam int X = 8;
  localparam int Y = 2;
`ifdef PIXEL_UNPACKER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] in_stream_tdata;
  logic        in_stream_tvalid, in_stream_tready, in_stream_tlast, in_stream_tuser;
  logic [3:0]  in_stream_tkeep;
  logic [7:0]  r, g, b;
  logic        valid, ready, sof, eol, sof_err, eol_err, err_clr;
  logic [10:0] x, y;

  pixel_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(in_stream_tdata), .in_stream_tvalid(in_stream_tvalid),
    .in_stream_tready(in_stream_tready), .in_stream_tlast(in_stream_tlast),
    .in_stream_tuser(in_stream_tuser), .in_stream_tkeep(in_stream_tkeep),
    .r(r), .g(g), .b(b), .valid(valid), .ready(ready), .sof(sof), .eol(eol),
    .x(x), .y(y), .sof_err(sof_err), .eol_err(eol_err), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  int          vectors, miscompares, stab_viol;
  pix_t        exp_q[$], obs_q[$];
  logic [31:0] wd[$];
  bit          wu[$], wl[$];
  int          m_k, m_x, m_y;
  logic [31:0] m_w0, m_w1;
  bit          e_sof, e_eol, hold;
  pix_t        held;

  // ---------------- reference model: groups of three words, pixel counter ----------------
  function automatic pix_t mk(input logic [23:0] rgb, input int px, input int py);
    pix_t p;
    p.rgb = rgb;
    p.x   = 11'(px);
    p.y   = 11'(py);
    p.sof = (px == 0) && (py == 0);
    p.eol = (px == X - 1);
    return p;
  endfunction

  task automatic m_push(input logic [23:0] rgb);
    exp_q.push_back(mk(rgb, m_x, m_y));
    m_x++;
    if (m_x == X) begin
      m_x = 0;
      m_y = (m_y + 1) % Y;
    end
  endtask

  task automatic model_word(input logic [31:0] d, input bit u, input bit l,
                            output bit s_sof, output bit s_eol);
    s_sof = 1'b0;
    if (u) begin
      s_sof = (m_k != 0);
      m_k = 0; m_x = 0; m_y = 0;
    end else if (m_k == 0 && m_x == 0 && m_y == 0) begin
      s_sof = 1'b1;
    end
    s_eol = (l != (m_k == 2 && m_x == X - 2));
    case (m_k)
      0: begin m_w0 = d; m_push(d[23:0]); end
      1: begin m_w1 = d; m_push({d[15:0], m_w0[31:24]}); end
      default: begin m_push({d[7:0], m_w1[31:16]}); m_push(d[31:8]); end
    endcase
    m_k = (m_k + 1) % 3;
  endtask

  // ---------------- drivers ----------------
  task automatic step(input bit tv, input logic [31:0] d, input bit tu, input bit tl,
                      input bit rd, input bit clr, output bit acc);
    bit   ss, se;
    pix_t cur;
    @(posedge aclk); #1;
    in_stream_tvalid = tv; in_stream_tdata = d; in_stream_tuser = tu; in_stream_tlast = tl;
    in_stream_tkeep = 4'($urandom); ready = rd; err_clr = clr;
    @(negedge aclk);
    cur.rgb = {r, g, b}; cur.x = x; cur.y = y; cur.sof = sof; cur.eol = eol;
    if (hold && (!valid || cur !== held)) stab_viol++;
    hold = valid && !ready;
    held = cur;
    if (valid && ready) obs_q.push_back(cur);
    acc = tv && in_stream_tready;
    ss = 1'b0; se = 1'b0;
    if (acc) model_word(d, tu, tl, ss, se);
    e_sof = ss || (e_sof && !clr);
    e_eol = se || (e_eol && !clr);
  endtask

  task automatic apply_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0; in_stream_tvalid = 1'b0; in_stream_tuser = 1'b0;
    in_stream_tlast = 1'b0; ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    m_k = 0; m_x = 0; m_y = 0; e_sof = 1'b0; e_eol = 1'b0; hold = 1'b0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic load_words(input int n);
    wd.delete(); wu.delete(); wl.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back($urandom);
      wu.push_back(1'b0);
      wl.push_back(1'b0);
    end
  endtask

  task automatic run_words(input int n, input int vpct, input int rpct);
    int i, guard;
    bit tv, rd, acc;
    i = 0; guard = 0;
    while ((i < n || obs_q.size() != exp_q.size()) && guard < 2000) begin
      tv = (i < n) && ($urandom_range(99) < vpct);
      rd = ($urandom_range(99) < rpct);
      if (tv) step(1'b1, wd[i], wu[i], wl[i], rd, 1'b0, acc);
      else    step(1'b0, $urandom, 1'b0, 1'b0, rd, 1'b0, acc);
      if (acc) i++;
      guard++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_stream_tvalid = 1'b1; ready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    vectors++;
    if (in_stream_tready !== 1'b0) begin
      miscompares++; $display("FAIL reset_tready: got %b want 0", in_stream_tready);
    end
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    vectors++;
    if ({x, y, sof, eol, r, g, b, sof_err, eol_err} !== 50'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got x=%0d y=%0d sof=%b eol=%b rgb=%h errs=%b%b want all 0",
               x, y, sof, eol, {r, g, b}, sof_err, eol_err);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1; in_stream_tvalid = 1'b0;
    m_k = 0; m_x = 0; m_y = 0; e_sof = 1'b0; e_eol = 1'b0; hold = 1'b0;
    exp_q.delete(); obs_q.delete();
    begin
      bit acc;
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    end
    vectors++;
    if (in_stream_tready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_tready: got %b want 1", in_stream_tready);
    end
  endtask

  task automatic test_vector();
    logic [31:0] w[3];
    logic [23:0] px[4];
    bit          acc;
    w[0] = 32'h44332211; w[1] = 32'h88776655; w[2] = 32'hCCBBAA99;
    px[0] = 24'h332211; px[1] = 24'h665544; px[2] = 24'h998877; px[3] = 24'hCCBBAA;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, w[i], (i == 0), 1'b0, 1'b1, 1'b0, acc);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++; $display("FAIL vec_accept[%0d]: got %b want 1", i, acc);
      end
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    vectors++;
    if (in_stream_tready !== 1'b0) begin
      miscompares++; $display("FAIL vec_tready_p3: got %b want 0", in_stream_tready);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    vectors++;
    if (obs_q.size() !== 4) begin
      miscompares++; $display("FAIL vec_count: got %0d pixels want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].rgb !== px[i] || obs_q[i].x !== 11'(i) || obs_q[i].y !== 11'd0) begin
        miscompares++;
        $display("FAIL vec_pix[%0d]: got rgb=%h x=%0d y=%0d want rgb=%h x=%0d y=0",
                 i, obs_q[i].rgb, obs_q[i].x, obs_q[i].y, px[i], i);
      end
    end
  endtask

  task automatic test_frame();
    int nsof;
    apply_reset();
    load_words(24);
    wu[0] = 1'b1; wu[12] = 1'b1;
    wl[5] = 1'b1; wl[11] = 1'b1; wl[17] = 1'b1; wl[23] = 1'b1;
    stab_viol = 0;
    run_words(24, 70, 60);
    vectors++;
    if (obs_q.size() !== 32 || exp_q.size() !== 32) begin
      miscompares++;
      $display("FAIL frame_count: got %0d pixels (model %0d) want 32", obs_q.size(), exp_q.size());
    end
    nsof = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL frame_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].sof) nsof++;
    end
    vectors++;
    if (nsof !== 2) begin
      miscompares++; $display("FAIL frame_sof_count: got %0d want 2", nsof);
    end
    vectors++;
    if (stab_viol !== 0) begin
      miscompares++; $display("FAIL frame_hold_stable: got %0d violations want 0", stab_viol);
    end
    vectors++;
    if (sof_err !== 1'b0 || eol_err !== 1'b0) begin
      miscompares++; $display("FAIL frame_errs: got sof_err=%b eol_err=%b want 0 0", sof_err, eol_err);
    end
  endtask

  task automatic test_sof_err();
    apply_reset();
    load_words(4);
    wu[0] = 1'b1; wu[1] = 1'b1;
    run_words(4, 80, 70);
    vectors++;
    if (obs_q.size() !== 5) begin
      miscompares++; $display("FAIL sof_count: got %0d pixels want 5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL sof_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 1) begin
      vectors++;
      if (obs_q[1].x !== 11'd0 || obs_q[1].y !== 11'd0 || obs_q[1].rgb !== wd[1][23:0]) begin
        miscompares++;
        $display("FAIL sof_restart: got x=%0d y=%0d rgb=%h want x=0 y=0 rgb=%h",
                 obs_q[1].x, obs_q[1].y, obs_q[1].rgb, wd[1][23:0]);
      end
    end
    vectors++;
    if (sof_err !== CHK || eol_err !== 1'b0) begin
      miscompares++; $display("FAIL sof_err_flag: got sof_err=%b eol_err=%b want %b 0", sof_err, eol_err, CHK);
    end
  endtask

  task automatic test_eol_err();
    bit acc;
    apply_reset();
    load_words(6);
    wu[0] = 1'b1; wl[4] = 1'b1;
    run_words(6, 80, 70);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL eol_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (eol_err !== CHK || sof_err !== 1'b0) begin
      miscompares++; $display("FAIL eol_err_set: got eol_err=%b sof_err=%b want %b 0", eol_err, sof_err, CHK);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    vectors++;
    if (eol_err !== 1'b0) begin
      miscompares++; $display("FAIL eol_err_clear: got %b want 0", eol_err);
    end
    // wrong tlast on the same cycle as err_clr: the new error must win
    step(1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    vectors++;
    if (eol_err !== (CHK && e_eol)) begin
      miscompares++; $display("FAIL eol_err_priority: got %b want %b", eol_err, CHK && e_eol);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    apply_reset();
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    @(posedge aclk); #1;
    aresetn = 1'b0; in_stream_tvalid = 1'b1;
    @(negedge aclk);
    vectors++;
    if (in_stream_tready !== 1'b0 || valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_during: got tready=%b valid=%b want 0 0", in_stream_tready, valid);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1; in_stream_tvalid = 1'b0;
    m_k = 0; m_x = 0; m_y = 0; e_sof = 1'b0; e_eol = 1'b0; hold = 1'b0;
    exp_q.delete(); obs_q.delete();
    load_words(3);
    run_words(3, 100, 100);
    vectors++;
    if (obs_q.size() !== 4) begin
      miscompares++; $display("FAIL midrst_count: got %0d pixels want 4", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      vectors++;
      if (obs_q[0].rgb !== wd[0][23:0] || obs_q[0].x !== 11'd0 || obs_q[0].y !== 11'd0) begin
        miscompares++;
        $display("FAIL midrst_first: got rgb=%h x=%0d y=%0d want rgb=%h x=0 y=0",
                 obs_q[0].rgb, obs_q[0].x, obs_q[0].y, wd[0][23:0]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL midrst_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (sof_err !== (CHK && e_sof)) begin
      miscompares++; $display("FAIL midrst_sof_err: got %b want %b", sof_err, CHK && e_sof);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; stab_viol = 0;
    aresetn = 1'b0; in_stream_tvalid = 1'b0; in_stream_tdata = 32'd0;
    in_stream_tuser = 1'b0; in_stream_tlast = 1'b0; in_stream_tkeep = 4'd0;
    ready = 1'b0; err_clr = 1'b0;
    m_k = 0; m_x = 0; m_y = 0; e_sof = 1'b0; e_eol = 1'b0; hold = 1'b0;
    test_reset();
    test_vector();
    test_frame();
    test_sof_err();
    test_eol_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
